// File: rtl/cu_initiator.sv
// cu_initiator
// Serial command initiator. It accepts one command at a time from upstream,
// selects the target (shift-register file or RAM) and shifts the payload out
// (writes) or in (reads) LSB first. It then waits for the target's done
// strobe, with a timeout, and returns a single-cycle response.
//
// Ports
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   req        command request, accepted only while req_ready is high
//   wr         1 = write, 0 = read
//   tgt        0 = shift-register file, 1 = RAM
//   cmd_addr   target address
//   wdata      write payload
//   req_ready  high only while idle
//   chip_sel   00 = SRF, 01 = RAM, 11 = nothing selected
//   addr       address presented to the target
//   data_out   serial write data
//   data_in    serial read data
//   done       target completion strobe (looked at only while waiting)
//   rsp_valid  one-cycle response pulse
//   rdata      last read result
//   err        timeout flag of the last response
module cu_initiator #(
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req,
    input  logic              wr,
    input  logic              tgt,
    input  logic [2:0]        cmd_addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              req_ready,
    output logic [1:0]        chip_sel,
    output logic [2:0]        addr,
    output logic              data_out,
    input  logic              data_in,
    input  logic              done,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rdata,
    output logic              err
);

    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam int TMO_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(DATA_W - 1);
    localparam logic [TMO_W-1:0] LAST_WAIT = TMO_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT_OUT,
        SHIFT_IN,
        WAIT_DONE,
        RESP
    } state_t;

    state_t            state_reg;
    logic              wr_reg;
    logic [DATA_W-1:0] shift_reg;    // payload going out, or bits coming in
    logic [CNT_W-1:0]  bit_cnt_reg;
    logic [TMO_W-1:0]  tmo_cnt_reg;

    // Read shift: the new bit enters at the MSB, so after DATA_W samples the
    // first bit sampled sits in bit 0.
    logic [DATA_W:0] shift_in_next;
    assign shift_in_next = {data_in, shift_reg};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            wr_reg      <= 1'b0;
            shift_reg   <= '0;
            bit_cnt_reg <= '0;
            tmo_cnt_reg <= '0;
            req_ready   <= 1'b1;
            chip_sel    <= 2'b11;
            addr        <= 3'd0;
            data_out    <= 1'b0;
            rsp_valid   <= 1'b0;
            rdata       <= '0;
            err         <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (req) begin
                        wr_reg      <= wr;
                        shift_reg   <= wdata;
                        chip_sel    <= {1'b0, tgt};
                        addr        <= cmd_addr;
                        data_out    <= 1'b0;
                        req_ready   <= 1'b0;
                        bit_cnt_reg <= '0;
                        state_reg   <= SETUP;
                    end
                end

                SETUP: begin
                    bit_cnt_reg <= '0;
                    if (wr_reg) begin
                        // First payload bit goes out on the edge leaving SETUP.
                        data_out  <= shift_reg[0];
                        shift_reg <= shift_reg >> 1;
                        state_reg <= SHIFT_OUT;
                    end else begin
                        state_reg <= SHIFT_IN;
                    end
                end

                SHIFT_OUT: begin
                    if (bit_cnt_reg == LAST_BIT) begin
                        data_out    <= 1'b0;
                        tmo_cnt_reg <= '0;
                        state_reg   <= WAIT_DONE;
                    end else begin
                        data_out    <= shift_reg[0];
                        shift_reg   <= shift_reg >> 1;
                        bit_cnt_reg <= bit_cnt_reg + CNT_W'(1);
                    end
                end

                SHIFT_IN: begin
                    shift_reg <= shift_in_next[DATA_W:1];
                    if (bit_cnt_reg == LAST_BIT) begin
                        tmo_cnt_reg <= '0;
                        state_reg   <= WAIT_DONE;
                    end else begin
                        bit_cnt_reg <= bit_cnt_reg + CNT_W'(1);
                    end
                end

                WAIT_DONE: begin
                    // done is tested first so it wins over a simultaneous timeout.
                    if (done || (tmo_cnt_reg == LAST_WAIT)) begin
                        err       <= ~done;
                        rsp_valid <= 1'b1;
                        chip_sel  <= 2'b11;
                        data_out  <= 1'b0;
                        if (!wr_reg) begin
                            rdata <= shift_reg;
                        end
                        state_reg <= RESP;
                    end else begin
                        tmo_cnt_reg <= tmo_cnt_reg + TMO_W'(1);
                    end
                end

                RESP: begin
                    rsp_valid <= 1'b0;
                    req_ready <= 1'b1;
                    state_reg <= IDLE;
                end

                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cu_initiator.sv
// Testbench for cu_initiator. A driver issues commands and pushes the expected
// response into a queue. A monitor follows each transaction from chip-select
// assertion to the response pulse and compares it against the queued record.
module tb_cu_initiator;

    localparam int DATA_W  = 8;
    localparam int TIMEOUT = 15;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              req = 1'b0;
    logic              wr = 1'b0;
    logic              tgt = 1'b0;
    logic [2:0]        cmd_addr = 3'd0;
    logic [DATA_W-1:0] wdata = '0;
    logic              req_ready;
    logic [1:0]        chip_sel;
    logic [2:0]        addr;
    logic              data_out;
    logic              data_in = 1'b0;
    logic              done = 1'b0;
    logic              rsp_valid;
    logic [DATA_W-1:0] rdata;
    logic              err;

    cu_initiator #(.DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .wr        (wr),
        .tgt       (tgt),
        .cmd_addr  (cmd_addr),
        .wdata     (wdata),
        .req_ready (req_ready),
        .chip_sel  (chip_sel),
        .addr      (addr),
        .data_out  (data_out),
        .data_in   (data_in),
        .done      (done),
        .rsp_valid (rsp_valid),
        .rdata     (rdata),
        .err       (err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit                wr;
        bit                tgt;
        logic [2:0]        addr;
        logic [DATA_W-1:0] wdata;
        logic [DATA_W-1:0] rdata;
        bit                err;
        int                acc;   // cycle stamp of the accept edge
        int                wn;    // WAIT_DONE edges until the response
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   n_txn = 0;
    bit   mon_en = 1'b0;
    logic [DATA_W-1:0] exp_rdata = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, want, $time);
        end
    endtask

    // d: the WAIT_DONE edge (1-based) at which done is seen high; d > TIMEOUT
    // means done never comes. noise: 0 quiet, 1 random done/req, 2 done held
    // high through setup and shifting. rel: release reset with the request.
    task automatic do_txn(input bit w, input bit t, input logic [2:0] a,
                          input logic [DATA_W-1:0] wd, input logic [DATA_W-1:0] rb,
                          input int d, input int noise, input bit rel);
        exp_t e;
        int   guard;
        int   wn;
        wn = (d > TIMEOUT) ? TIMEOUT : d;
        guard = 0;
        @(negedge clk);
        while (!req_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (!req_ready) begin
            chk("req_ready_wait", 32'(req_ready), 32'd1);
            return;
        end
        req = 1'b1;
        wr = w;
        tgt = t;
        cmd_addr = a;
        wdata = wd;
        if (rel) rst_n = 1'b1;
        @(posedge clk);
        #1;
        if (!w) exp_rdata = rb;
        e.wr = w;
        e.tgt = t;
        e.addr = a;
        e.wdata = wd;
        e.rdata = exp_rdata;
        e.err = (d > TIMEOUT);
        e.acc = cyc;
        e.wn = wn;
        exp_q.push_back(e);
        for (int j = 1; j <= DATA_W + 1 + wn; j++) begin
            req = (noise != 0) ? 1'($urandom_range(0, 1)) : 1'b0;
            wr = 1'($urandom_range(0, 1));
            tgt = 1'($urandom_range(0, 1));
            cmd_addr = 3'($urandom);
            wdata = DATA_W'($urandom);
            data_in = (j >= 2 && j <= DATA_W + 1) ? rb[j-2] : 1'($urandom_range(0, 1));
            if (j <= DATA_W + 1)
                done = (noise == 2) ? 1'b1 : ((noise == 1) ? 1'($urandom_range(0, 1)) : 1'b0);
            else
                done = ((j - DATA_W - 1) == d);
            @(posedge clk);
            #1;
        end
        req = 1'b0;
        done = 1'b0;
        data_in = 1'b0;
    endtask

    // Monitor: follows each transaction from SETUP through the response.
    initial begin
        int   phase;
        int   k;
        exp_t cur;
        phase = 0;
        k = 0;
        forever begin
            @(negedge clk);
            if (!rst_n || !mon_en) begin
                phase = 0;
                continue;
            end
            case (phase)
                0: begin
                    chk("idle_rsp_valid", 32'(rsp_valid), 32'd0);
                    if (chip_sel != 2'b11) begin
                        if (exp_q.size() == 0) begin
                            chk("unexpected_setup", 32'(chip_sel), 32'd3);
                        end else begin
                            cur = exp_q.pop_front();
                            chk("setup_cycle", 32'(cyc), 32'(cur.acc));
                            chk("setup_chip_sel", 32'(chip_sel), 32'({1'b0, cur.tgt}));
                            chk("setup_addr", 32'(addr), 32'(cur.addr));
                            chk("setup_data_out", 32'(data_out), 32'd0);
                            k = 0;
                            phase = 1;
                        end
                    end
                end
                1: begin
                    chk("shift_chip_sel", 32'(chip_sel), 32'({1'b0, cur.tgt}));
                    chk("shift_addr", 32'(addr), 32'(cur.addr));
                    chk("shift_data_out", 32'(data_out), cur.wr ? 32'(cur.wdata[k]) : 32'd0);
                    chk("shift_rsp_valid", 32'(rsp_valid), 32'd0);
                    k++;
                    if (k == DATA_W) phase = 2;
                end
                2: begin
                    if (rsp_valid) begin
                        chk("rsp_latency", 32'(cyc), 32'(cur.acc + DATA_W + 1 + cur.wn));
                        chk("rsp_err", 32'(err), 32'(cur.err));
                        chk("rsp_rdata", 32'(rdata), 32'(cur.rdata));
                        chk("rsp_chip_sel", 32'(chip_sel), 32'd3);
                        chk("rsp_data_out", 32'(data_out), 32'd0);
                        chk("rsp_req_ready", 32'(req_ready), 32'd0);
                        n_txn++;
                        $display("txn %0d: %s tgt=%0d addr=%0d wdata=%02h rdata=%02h err=%0d wait=%0d",
                                 n_txn, cur.wr ? "write" : "read ", cur.tgt, cur.addr,
                                 cur.wdata, rdata, err, cur.wn);
                        phase = 3;
                    end else begin
                        chk("wait_chip_sel", 32'(chip_sel), 32'({1'b0, cur.tgt}));
                        chk("wait_addr", 32'(addr), 32'(cur.addr));
                        if (cyc > cur.acc + DATA_W + 1 + TIMEOUT + 2) begin
                            chk("rsp_missing", 32'(rsp_valid), 32'd1);
                            phase = 0;
                        end
                    end
                end
                default: begin
                    chk("rsp_one_cycle", 32'(rsp_valid), 32'd0);
                    chk("post_rsp_req_ready", 32'(req_ready), 32'd1);
                    phase = 0;
                end
            endcase
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, n_cmp=%0d", n_cmp);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_chip_sel", 32'(chip_sel), 32'd3);
        chk("reset_addr", 32'(addr), 32'd0);
        chk("reset_data_out", 32'(data_out), 32'd0);
        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset_rdata", 32'(rdata), 32'd0);
        chk("reset_err", 32'(err), 32'd0);
        chk("reset_req_ready", 32'(req_ready), 32'd1);
        mon_en = 1'b1;

        // Write accepted on the first edge after reset release, immediate done.
        do_txn(1'b1, 1'b0, 3'd5, 8'hA5, 8'h00, 1, 0, 1'b1);
        // Read, data_in 0,1,1,0,1,0,0,1 LSB first.
        do_txn(1'b0, 1'b1, 3'd3, 8'h00, 8'h96, 1, 0, 1'b0);
        // Timeout with done held low.
        do_txn(1'b1, 1'b0, 3'd2, 8'h3C, 8'h00, TIMEOUT + 3, 0, 1'b0);
        // Early done during shifting, then nothing: must time out.
        do_txn(1'b1, 1'b1, 3'd7, 8'hC3, 8'h00, TIMEOUT + 2, 2, 1'b0);
        // done arrives on the last WAIT_DONE edge: done wins.
        do_txn(1'b0, 1'b0, 3'd1, 8'h00, 8'h5E, TIMEOUT, 1, 1'b0);

        // Abort a read during bit 4 of SHIFT_IN.
        mon_en = 1'b0;
        @(negedge clk);
        req = 1'b1;
        wr = 1'b0;
        tgt = 1'b1;
        cmd_addr = 3'd6;
        @(posedge clk);
        #1;
        req = 1'b0;
        data_in = 1'b1;
        done = 1'b1;
        repeat (5) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        exp_rdata = '0;
        chk("abort_chip_sel", 32'(chip_sel), 32'd3);
        chk("abort_addr", 32'(addr), 32'd0);
        chk("abort_data_out", 32'(data_out), 32'd0);
        chk("abort_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("abort_rdata", 32'(rdata), 32'd0);
        chk("abort_err", 32'(err), 32'd0);
        chk("abort_req_ready", 32'(req_ready), 32'd1);
        repeat (2) begin
            @(negedge clk);
            chk("abort_hold_rsp_valid", 32'(rsp_valid), 32'd0);
            chk("abort_hold_chip_sel", 32'(chip_sel), 32'd3);
        end
        data_in = 1'b0;
        done = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_abort_rsp_valid", 32'(rsp_valid), 32'd0);
        mon_en = 1'b1;
        do_txn(1'b1, 1'b0, 3'd4, 8'h69, 8'h00, 2, 0, 1'b0);

        // Randomized commands.
        for (int i = 0; i < 30; i++) begin
            bit   w;
            bit   t;
            int   d;
            int   r;
            w = 1'($urandom_range(0, 1));
            t = 1'($urandom_range(0, 1));
            r = $urandom_range(0, 3);
            d = (r == 0) ? (TIMEOUT + 1 + $urandom_range(0, 3)) : $urandom_range(1, TIMEOUT);
            do_txn(w, t, 3'($urandom), DATA_W'($urandom), DATA_W'($urandom),
                   d, $urandom_range(0, 2), 1'b0);
        end

        repeat (DATA_W + TIMEOUT + 6) @(negedge clk);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/cu_initiator.md
CU_INITIATOR -- requirements
Module: cu_initiator

Interface
REQ-001 Parameter: DATA_W, default 8, serial payload width in bits.
REQ-002 Parameter: TIMEOUT, default 15, maximum WAIT_DONE cycles before error.
REQ-003 clk  input  1  system clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 req  input  1  command request from upstream; qualified by req_ready.
REQ-006 wr  input  1  1 = write, 0 = read.
REQ-007 tgt  input  1  0 = shift-register file, 1 = RAM.
REQ-008 cmd_addr  input  3  target address.
REQ-009 wdata  input  DATA_W  write payload.
REQ-010 req_ready  output  1  high only in IDLE.
REQ-011 chip_sel  output  2  target select: 00 = SRF, 01 = RAM, 11 = none; 10 is never driven.
REQ-012 addr  output  3  address to target.
REQ-013 data_out  output  1  serial write data to target.
REQ-014 data_in  input  1  serial read data from target.
REQ-015 done  input  1  target completion strobe.
REQ-016 rsp_valid  output  1  one-cycle response pulse.
REQ-017 rdata  output  DATA_W  read result; valid with rsp_valid on reads.
REQ-018 err  output  1  timeout flag; valid with rsp_valid.

Function
REQ-019 FSM states SHALL be IDLE, SETUP, SHIFT_OUT, SHIFT_IN, WAIT_DONE, RESP.
REQ-020 In IDLE: req && req_ready latches wr, tgt, cmd_addr and wdata, then moves to SETUP.
REQ-021 req in any state other than IDLE SHALL be ignored, with no queuing.
REQ-022 SETUP lasts 1 cycle: chip_sel = {1'b0,tgt}, addr = latched address, data_out = 0.
REQ-023 chip_sel and addr SHALL hold their values from SETUP through WAIT_DONE.
REQ-024 After SETUP, a write goes to SHIFT_OUT and a read goes to SHIFT_IN.
REQ-025 SHIFT_OUT lasts exactly DATA_W cycles; data_out = wdata[k] in the k-th cycle (k = 0..DATA_W-1, LSB first); then WAIT_DONE.
REQ-026 SHIFT_IN lasts exactly DATA_W cycles; data_in is sampled at the end of each cycle into rdata[k], LSB first; then WAIT_DONE.
REQ-027 Bit counter width = clog2(DATA_W); it clears on SETUP and never wraps mid-shift.
REQ-028 done SHALL be ignored outside WAIT_DONE, so an early done does not end the transaction.
REQ-029 WAIT_DONE: done sampled high → RESP with err = 0.
REQ-030 WAIT_DONE: after TIMEOUT consecutive cycles with done low → RESP with err = 1.
REQ-031 If done is high in the same cycle the timeout expires, done wins (err = 0).
REQ-032 RESP lasts 1 cycle: rsp_valid = 1, chip_sel = 11, data_out = 0; then IDLE.
REQ-033 Latency: with done high on entry to WAIT_DONE, rsp_valid SHALL rise DATA_W+2 clock edges after the accept edge.
REQ-034 On writes, rdata SHALL retain its previous value; on reads, it holds until the next read response.
REQ-035 err SHALL hold until the next RESP.
REQ-036 Back-to-back: req_ready is high the cycle after RESP, giving a minimum of 1 idle cycle between transactions.

Reset
REQ-037 While rst_n = 0: state = IDLE, chip_sel = 11, addr = 0, data_out = 0, rsp_valid = 0, rdata = 0, err = 0, counters = 0, req_ready = 1.
REQ-038 rst_n asserted mid-transaction SHALL abort immediately, with no rsp_valid pulse and chip_sel = 11 asynchronously.
REQ-039 The first command SHALL be accepted on the first rising edge with rst_n = 1.

Verification
REQ-040 Write: tgt = 0, addr = 5, wdata = 8'hA5, done high at WAIT_DONE → chip_sel = 00, data_out sequence 1,0,1,0,0,1,0,1, rsp_valid 10 edges after accept, err = 0.
REQ-041 Read: tgt = 1, addr = 3, data_in sequence 0,1,1,0,1,0,0,1 → chip_sel = 01, rdata = 8'h96, err = 0.
REQ-042 Timeout: done held low → rsp_valid 15 cycles after WAIT_DONE entry, err = 1, chip_sel returns to 11.
REQ-043 Early done: done pulsed during SHIFT_OUT, then low → timeout path is taken (err = 1).
REQ-044 Timeout race: done rises in the 15th WAIT_DONE cycle → err = 0.
REQ-045 Abort: rst_n pulsed low during SHIFT_IN bit 4 → outputs at reset values, no rsp_valid; a new write is accepted and completes normally.
